// File: rtl/keypad_scan.sv
// keypad_scan
//   Scans a 4x4 matrix keypad one column at a time and reports debounced key
//   presses to the calculator core.
//   Column drives are active-low and one-hot-zero. Row inputs are active-low
//   because the board pulls them up.
//   Each accepted press updates `key` and pulses `key_valid` for one clock.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   rows       in   4  keypad rows, active-low, asynchronous to clk
//   cols       out  4  column drive, active-low, one-hot-zero (4'b1111 in reset)
//   key        out  4  accepted key index = row*4 + col, held until next accept
//   key_valid  out  1  one-cycle strobe when key is (re)issued
//   key_held   out  1  high while the accepted key is considered down
//
// Parameters
//   SCAN_DIV    clocks per column slot (>=4); one frame = 4*SCAN_DIV clocks
//   DEB_FRAMES  identical consecutive frames needed to accept a press/release
//   REPEAT_DLY  frames held before the first auto-repeat
//   REPEAT_RATE frames between later auto-repeats
//
// Configuration
//   KEYPAD_REPEAT_EN  when defined, a held key re-strobes key_valid after
//                     REPEAT_DLY frames and then every REPEAT_RATE frames.
//                     When undefined, exactly one strobe per accepted press.
module keypad_scan #(
  parameter int SCAN_DIV    = 256,
  parameter int DEB_FRAMES  = 4,
  parameter int REPEAT_DLY  = 32,
  parameter int REPEAT_RATE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEB_FRAMES + 1);

  if (SCAN_DIV < 4)    $error("keypad_scan: SCAN_DIV must be >= 4");
  if (DEB_FRAMES < 1)  $error("keypad_scan: DEB_FRAMES must be >= 1");
  if (REPEAT_DLY < 1)  $error("keypad_scan: REPEAT_DLY must be >= 1");
  if (REPEAT_RATE < 1) $error("keypad_scan: REPEAT_RATE must be >= 1");

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  // Scan timing
  logic              run_q, run_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_q, col_d;
  logic              last_slot, frame_end;

  // Row synchronizer and per-frame press map (bit index = row*4 + col)
  logic [3:0]  rows_s1_q, rows_s1_d;
  logic [3:0]  rows_s2_q, rows_s2_d;
  logic [15:0] frame_q, frame_d;
  logic [4:0]  hit_cnt;
  logic [3:0]  hit_idx;
  logic        is_none, is_single;

  // Debounce FSM and outputs
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = 16;
  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
  logic             rep_first_q, rep_first_d;
  assign rep_inc = rep_q + REP_W'(1);
`endif

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last_slot = run_q && (slot_q == SLOT_W'(SCAN_DIV - 1));
  assign frame_end = last_slot && (col_q == 2'd3);

  assign cols      = run_q ? ~(4'b0001 << col_q) : 4'b1111;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

  // Stage: scan counters and row sampling
  always_comb begin
    run_d     = 1'b1;
    slot_d    = slot_q;
    col_d     = col_q;
    rows_s1_d = rows;
    rows_s2_d = rows_s1_q;
    frame_d   = frame_q;
    // The cycle that leaves reset only arms the scan, so column 0 gets a full slot.
    if (run_q) begin
      if (last_slot) begin
        slot_d = '0;
        col_d  = col_q + 2'd1;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
    // Overwrite this column's four bits; the column-3 sample is used the same cycle.
    if (last_slot) begin
      for (int r = 0; r < 4; r++) begin
        frame_d[{2'(r), col_q}] = !rows_s2_q[r];
      end
    end
  end

  // Stage: frame classification
  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int k = 0; k < 16; k++) begin
      if (frame_d[k]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(k);
      end
    end
    is_none   = (hit_cnt == 5'd0);
    is_single = (hit_cnt == 5'd1);
  end

  // Stage: debounce FSM, evaluated once per frame end
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
    // Any frame end that is not a PRESSED->PRESSED hold restarts the repeat timing.
    if (frame_end) begin
      rep_d       = '0;
      rep_first_d = 1'b0;
    end
`endif
    if (frame_end) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_single) begin
            cand_d  = hit_idx;
            cnt_d   = CNT_W'(1);
            state_d = ST_DEBOUNCE;
            accept  = (DEB_FRAMES == 1);
          end
        end
        ST_DEBOUNCE: begin
          if (is_single && hit_idx == cand_q) begin
            cnt_d  = cnt_inc;
            accept = (cnt_inc >= CNT_W'(DEB_FRAMES));
          end else if (is_single) begin
            cand_d = hit_idx;
            cnt_d  = CNT_W'(1);
            accept = (DEB_FRAMES == 1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (is_none) begin
            if (DEB_FRAMES == 1) begin
              state_d    = ST_IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            // Still held (extra keys are ignored): advance the repeat timer.
            rep_d       = rep_inc;
            rep_first_d = rep_first_q;
            if (!rep_first_q && rep_inc == REP_W'(REPEAT_DLY)) begin
              key_valid_d = 1'b1;
              rep_d       = '0;
              rep_first_d = 1'b1;
            end else if (rep_first_q && rep_inc == REP_W'(REPEAT_RATE)) begin
              key_valid_d = 1'b1;
              rep_d       = '0;
            end
`endif
          end
        end
        ST_RELEASE: begin
          if (is_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_W'(DEB_FRAMES)) begin
              state_d    = ST_IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end
          end else begin
            // A bounce during release returns to the same hold without a new strobe.
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (accept) begin
        state_d     = ST_PRESSED;
        cnt_d       = '0;
        key_d       = cand_d;
        key_held_d  = 1'b1;
        key_valid_d = 1'b1;
      end
    end
  end

  // Stage: state registers
  always_ff @(posedge clk) begin
    rows_s1_q <= rows_s1_d;
    rows_s2_q <= rows_s2_d;
    frame_q   <= frame_d;
    if (rst) begin
      run_q       <= 1'b0;
      slot_q      <= '0;
      col_q       <= '0;
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      run_q       <= run_d;
      slot_q      <= slot_d;
      col_q       <= col_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q       <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
//   Drives a virtual 4x4 keypad (a 16-bit mask of held keys, row*4 + col) and
//   compares the scanner against a frame-level reference model of the debounce
//   rules: press accepted after DEB frames of one identical single key, release
//   after DEB empty frames, optional auto-repeat while held.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int DLY      = 4;
  localparam int RATE     = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] held = 16'h0000;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          hist[$];   // frame classes since the last accept/release
  bit          m_pressed;
  logic [3:0]  m_key;
  int          m_none_run;
  int          m_hold_n;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .DEB_FRAMES (DEB),
    .REPEAT_DLY (DLY),
    .REPEAT_RATE(RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rows     (rows),
    .cols     (cols),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Keypad matrix: a held key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // -1 = no key, -2 = several keys, otherwise the key index.
  function automatic int classify(input logic [15:0] m);
    int idx = 0;
    if ($countones(m) == 0) return -1;
    if ($countones(m) > 1) return -2;
    for (int k = 0; k < 16; k++) if (m[k]) idx = k;
    return idx;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_pressed  = 1'b0;
    m_key      = 4'd0;
    m_none_run = 0;
    m_hold_n   = 0;
  endtask

  task automatic model_frame(input logic [15:0] m, output bit strobe);
    int c;
    int run;
    c      = classify(m);
    strobe = 1'b0;
    if (!m_pressed) begin
      if (c < 0) hist.delete();
      else hist.push_back(c);
      run = 0;
      for (int i = hist.size() - 1; i >= 0 && hist[i] == c && c >= 0; i--) run++;
      if (c >= 0 && run >= DEB) begin
        m_pressed  = 1'b1;
        m_key      = 4'(c);
        strobe     = 1'b1;
        m_hold_n   = 0;
        m_none_run = 0;
        hist.delete();
      end
    end else if (c == -1) begin
      m_none_run++;
      m_hold_n = 0;
      if (m_none_run >= DEB) begin
        m_pressed  = 1'b0;
        m_none_run = 0;
        hist.delete();
      end
    end else begin
      if (m_none_run == 0) begin
        m_hold_n++;
`ifdef KEYPAD_REPEAT_EN
        if (m_hold_n == DLY || (m_hold_n > DLY && (m_hold_n - DLY) % RATE == 0))
          strobe = 1'b1;
`endif
      end else begin
        m_hold_n = 0;
      end
      m_none_run = 0;
    end
  endtask

  // Holds mask m for one full frame; called at the start of a frame.
  task automatic run_frame(input logic [15:0] m);
    bit          s;
    logic [3:0]  ec;
    held = m;
    model_frame(m, s);
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk);
      #1;
      ec = ~(4'b0001 << (((i + 1) % FRAME) / SCAN_DIV));
      check("cols", 16'(cols), 16'(ec));
      check("key_valid", 16'(key_valid), (i == FRAME - 1) ? 16'(s) : 16'h0);
      if (i == FRAME - 1) begin
        check("key", 16'(key), 16'(m_key));
        check("key_held", 16'(key_held), 16'(m_pressed));
      end
    end
  endtask

  task automatic run_frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m);
  endtask

  // Leaves the bench at the first cycle of a fresh frame.
  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    held = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cols", 16'(cols), 16'hF);
    check("rst_key", 16'(key), 16'h0);
    check("rst_key_valid", 16'(key_valid), 16'h0);
    check("rst_key_held", 16'(key_held), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    logic [15:0] m;
    int          sel;
    int          a;
    int          b;
    model_reset();

    // Idle scan
    do_reset();
    run_frames(16'h0000, 3);

    // Key 9 (row 2, column 1) held
    run_frames(16'h0200, 5);
    // Release and press again
    run_frames(16'h0000, 4);
    run_frames(16'h0200, 4);
    run_frames(16'h0000, 4);

    // Bouncing key 9: 2 present, 1 absent, 3 present
    run_frames(16'h0200, 2);
    run_frames(16'h0000, 1);
    run_frames(16'h0200, 3);
    run_frames(16'h0000, 4);

    // Keys 5 and 6 together from idle, then 5 alone followed by 5+6
    run_frames(16'h0060, 5);
    run_frames(16'h0000, 3);
    run_frames(16'h0020, 4);
    run_frames(16'h0060, 4);
    run_frames(16'h0000, 4);

    // Reset in the middle of a debounce
    run_frames(16'h0008, 2);
    repeat (5) @(posedge clk);
    do_reset();
    run_frames(16'h0000, 2);

    // Key 3 held for 12 frames (auto-repeat when enabled)
    run_frames(16'h0008, 12);
    run_frames(16'h0000, 4);

    // Randomized segments of none / single / double presses
    for (int seg = 0; seg < 70; seg++) begin
      sel = $urandom_range(0, 9);
      a   = $urandom_range(0, 15);
      b   = (a + $urandom_range(1, 15)) % 16;
      m   = 16'h0000;
      if (sel >= 3) m[a] = 1'b1;
      if (sel >= 8) m[b] = 1'b1;
      run_frames(m, $urandom_range(1, 5));
    end
    run_frames(16'h0000, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
